// File: rtl/relin_key_pkg.sv
// Shared types and elaboration helpers for the relinearization-key writer.
package relin_key_pkg;

    typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

    // Beats needed to fill both components of a key set.
    function automatic int beat_count(input int num, input int len, input int tile);
        return 2 * num * len / tile;
    endfunction

    function automatic bit tile_divides(input int len, input int tile);
        return (tile > 0) && ((len % tile) == 0);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/relin_key_wr_sequencer.sv
// Address counter chain: addr innermost, then key index, then component select.
module relin_key_wr_sequencer
    import relin_key_pkg::*;
#(
    parameter int RELIN_KEY_TILE_WIDTH = 8,
    parameter int RELIN_KEY_LENGTH     = 512,
    parameter int NUM_RELIN_KEYS       = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    clear_i,
    input  logic                                    advance_i,
    output logic [idx_w(RELIN_KEY_LENGTH)-1:0]      addr_o,
    output logic [idx_w(NUM_RELIN_KEYS)-1:0]        key_idx_o,
    output logic                                    c_sel_o,
    output logic                                    last_beat_o
);
    localparam int AW = idx_w(RELIN_KEY_LENGTH);
    localparam int KW = idx_w(NUM_RELIN_KEYS);

    logic [AW-1:0] addr_q, addr_d;
    logic [KW-1:0] key_q, key_d;
    logic          c_sel_q, c_sel_d;
    logic          addr_wrap, key_wrap;

    always_comb begin
        addr_wrap = (addr_q == AW'(RELIN_KEY_LENGTH - RELIN_KEY_TILE_WIDTH));
        key_wrap  = (key_q == KW'(NUM_RELIN_KEYS - 1));
        addr_d    = addr_q;
        key_d     = key_q;
        c_sel_d   = c_sel_q;
        if (clear_i) begin
            addr_d  = '0;
            key_d   = '0;
            c_sel_d = 1'b0;
        end else if (advance_i) begin
            if (addr_wrap) begin
                addr_d = '0;
                if (key_wrap) begin
                    key_d   = '0;
                    c_sel_d = ~c_sel_q;
                end else begin
                    key_d = key_q + KW'(1);
                end
            end else begin
                addr_d = addr_q + AW'(RELIN_KEY_TILE_WIDTH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            key_q   <= '0;
            c_sel_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            key_q   <= key_d;
            c_sel_q <= c_sel_d;
        end
    end

    assign addr_o      = addr_q;
    assign key_idx_o   = key_q;
    assign c_sel_o     = c_sel_q;
    assign last_beat_o = c_sel_q & key_wrap & addr_wrap;

endmodule

// File: rtl/relin_key_writer.sv
// Loads a full relin-key set from a valid/ready beat stream into the register file
// and reports completion, length errors and set validity to the tile loader.
module relin_key_writer
    import relin_key_pkg::*;
#(
    parameter int RELIN_KEY_TILE_WIDTH = 8,
    parameter int RELIN_KEY_LENGTH     = 512,
    parameter int NUM_RELIN_KEYS       = 8,
    parameter int DATA_WIDTH           = 64
) (
    input  logic                                                      clk,
    input  logic                                                      reset,
    input  logic                                                      start,
    input  logic                                                      in_valid,
    output logic                                                      in_ready,
    input  logic [RELIN_KEY_TILE_WIDTH*DATA_WIDTH-1:0]                in_tile,
    input  logic                                                      in_last,
    output logic                                                      busy,
    output logic                                                      done,
    output logic                                                      len_error,
    output logic                                                      keys_valid,
    output logic [2*NUM_RELIN_KEYS*RELIN_KEY_LENGTH*DATA_WIDTH-1:0]   relin_key_register_file
);
    localparam int TILE = RELIN_KEY_TILE_WIDTH;
    localparam int LEN  = RELIN_KEY_LENGTH;
    localparam int NUM  = NUM_RELIN_KEYS;
    localparam int DW   = DATA_WIDTH;
    localparam int AW   = idx_w(LEN);
    localparam int KW   = idx_w(NUM);

    if (!tile_divides(LEN, TILE)) begin : g_bad_tile
        $error("RELIN_KEY_TILE_WIDTH must divide RELIN_KEY_LENGTH");
    end

    state_t        state_q, state_d;
    logic          hs, finish, start_acc;
    logic          done_q, len_error_q, keys_valid_q;
    logic [AW-1:0] addr;
    logic [KW-1:0] key_idx;
    logic          c_sel, last_beat;
    logic [DW-1:0] mem_q [2][NUM][LEN];

    assign hs        = in_valid & (state_q == LOAD);
    assign finish    = hs & (last_beat | in_last);
    assign start_acc = start & (state_q == IDLE);

    relin_key_wr_sequencer #(
        .RELIN_KEY_TILE_WIDTH(TILE),
        .RELIN_KEY_LENGTH    (LEN),
        .NUM_RELIN_KEYS      (NUM)
    ) u_seq (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (start_acc | finish),
        .advance_i  (hs),
        .addr_o     (addr),
        .key_idx_o  (key_idx),
        .c_sel_o    (c_sel),
        .last_beat_o(last_beat)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)  state_d = LOAD;
            LOAD:    if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A finishing beat is good only if in_last lands exactly on the final beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q       <= 1'b0;
            len_error_q  <= 1'b0;
            keys_valid_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (start_acc) begin
                len_error_q  <= 1'b0;
                keys_valid_q <= 1'b0;
            end else if (finish) begin
                if (last_beat && in_last) keys_valid_q <= 1'b1;
                else                      len_error_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hs && !reset) begin
            for (int j = 0; j < TILE; j++) begin
                mem_q[c_sel][key_idx][addr + AW'(j)] <= in_tile[j*DW +: DW];
            end
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_c
        for (genvar k = 0; k < NUM; k++) begin : g_k
            for (genvar a = 0; a < LEN; a++) begin : g_a
                assign relin_key_register_file[((c*NUM + k)*LEN + a)*DW +: DW] = mem_q[c][k][a];
            end
        end
    end

    assign in_ready   = (state_q == LOAD);
    assign busy       = (state_q == LOAD);
    assign done       = done_q;
    assign len_error  = len_error_q;
    assign keys_valid = keys_valid_q;

endmodule
